// File: rtl/cla_pkg.sv
// Shared constants and helpers for the pipelined carry-lookahead adder.
// Optional feature macro: CLA_FLAGS_EN (signed-overflow and zero flags).
package cla_pkg;

  localparam int unsigned GROUP_W = 4;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Group generate/propagate pair produced by one 4-bit lookahead group
  typedef struct packed {
    logic gg;
    logic gp;
  } cla_gen_t;

  // Number of 4-bit groups in a WIDTH-bit operand
  function automatic int unsigned cla_num_groups(input int unsigned width);
    return width / GROUP_W;
  endfunction

  // Group generate/propagate from 4 bit-level g/p pairs
  function automatic cla_gen_t cla_group_gen(input logic [GROUP_W-1:0] g,
                                             input logic [GROUP_W-1:0] p);
    cla_gen_t r;
    r.gg = g[3]
         | (p[3] & g[2])
         | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0]);
    r.gp = &p;
    return r;
  endfunction

endpackage

// File: rtl/cla_group4.sv
// 4-bit lookahead carry unit: carries into each bit plus group GG/GP.
// o_c[i] is the carry into bit i of the group (o_c[0] == i_cin).
module cla_group4
  import cla_pkg::*;
(
  input  logic [GROUP_W-1:0] i_g,
  input  logic [GROUP_W-1:0] i_p,
  input  logic               i_cin,
  output logic [GROUP_W-1:0] o_c,
  output logic               o_gg,
  output logic               o_gp
);

  cla_gen_t w_gen;

  // Flattened per-bit carry equations, no ripple inside the group
  assign o_c[0] = i_cin;
  assign o_c[1] = i_g[0] | (i_p[0] & i_cin);
  assign o_c[2] = i_g[1] | (i_p[1] & i_g[0]) | (i_p[1] & i_p[0] & i_cin);
  assign o_c[3] = i_g[2] | (i_p[2] & i_g[1]) | (i_p[2] & i_p[1] & i_g[0])
                | (i_p[2] & i_p[1] & i_p[0] & i_cin);

  assign w_gen = cla_group_gen(i_g, i_p);
  assign o_gg  = w_gen.gg;
  assign o_gp  = w_gen.gp;

endmodule

// File: rtl/cla_pipe_adder.sv
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready.
// S1 registers bit and group generate/propagate, S2 resolves carries via a
// flattened group-level prefix and registers the result.
// Optional feature macro: CLA_FLAGS_EN adds ovf_o/zero_o.
module cla_pipe_adder
  import cla_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  input  logic             sub_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o
`ifdef CLA_FLAGS_EN
  ,
  output logic             ovf_o,
  output logic             zero_o
`endif
);

  localparam int unsigned NG  = cla_num_groups(WIDTH);
  localparam int unsigned MSB = WIDTH - 1;

  // ---------------- S1 combinational ----------------
  logic [WIDTH-1:0] w_bx;
  logic [WIDTH-1:0] w_g;
  logic [WIDTH-1:0] w_p;
  logic             w_cin;
  logic [NG-1:0]    w_gg;
  logic [NG-1:0]    w_gp;

  // ---------------- S1 registers ----------------
  logic             r_s1_valid;
  logic [WIDTH-1:0] r_s1_g;
  logic [WIDTH-1:0] r_s1_p;
  logic [NG-1:0]    r_s1_gg;
  logic [NG-1:0]    r_s1_gp;
  logic             r_s1_cin;
`ifdef CLA_FLAGS_EN
  logic             r_s1_a_msb;
  logic             r_s1_b_msb;
`endif

  // ---------------- S2 combinational ----------------
  logic [NG:0]      w_gc;
  logic [WIDTH-1:0] w_c;
  logic [WIDTH-1:0] w_sum;
  logic [NG-1:0]    w_s2_gg;
  logic [NG-1:0]    w_s2_gp;
`ifdef CLA_FLAGS_EN
  logic             w_ovf;
  logic             w_zero;
`endif

  // ---------------- Output registers ----------------
  logic             r_out_valid;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
`ifdef CLA_FLAGS_EN
  logic             r_ovf;
  logic             r_zero;
`endif

  // ---------------- Handshake ----------------
  logic w_s1_adv;
  logic w_accept;

  // S1 moves forward whenever the output stage is empty or being drained
  assign w_s1_adv   = r_s1_valid & (~r_out_valid | out_ready_i);
  assign in_ready_o = ~r_s1_valid | w_s1_adv;
  assign w_accept   = in_valid_i & in_ready_o;

  // Subtract is A + ~B + 1; cin_i is ignored in that mode
  assign w_bx  = (sub_i == OP_SUB) ? ~b_i : b_i;
  assign w_cin = (sub_i == OP_SUB) ? 1'b1 : cin_i;
  assign w_g   = a_i & w_bx;
  assign w_p   = a_i ^ w_bx;

  // Per-group GG/GP ahead of the S1 register
  for (genvar k = 0; k < NG; k++) begin : g_s1_grp
    cla_gen_t w_gen;
    assign w_gen   = cla_group_gen(w_g[k*GROUP_W +: GROUP_W], w_p[k*GROUP_W +: GROUP_W]);
    assign w_gg[k] = w_gen.gg;
    assign w_gp[k] = w_gen.gp;
  end

  // S1 pipeline register: operand-derived g/p, group GG/GP, effective cin
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_s1_valid <= 1'b0;
      r_s1_g     <= '0;
      r_s1_p     <= '0;
      r_s1_gg    <= '0;
      r_s1_gp    <= '0;
      r_s1_cin   <= 1'b0;
`ifdef CLA_FLAGS_EN
      r_s1_a_msb <= 1'b0;
      r_s1_b_msb <= 1'b0;
`endif
    end else begin
      if (w_accept) begin
        r_s1_valid <= 1'b1;
        r_s1_g     <= w_g;
        r_s1_p     <= w_p;
        r_s1_gg    <= w_gg;
        r_s1_gp    <= w_gp;
        r_s1_cin   <= w_cin;
`ifdef CLA_FLAGS_EN
        r_s1_a_msb <= a_i[MSB];
        r_s1_b_msb <= w_bx[MSB];
`endif
      end else if (w_s1_adv) begin
        r_s1_valid <= 1'b0;
      end
    end
  end

  // Group carry-ins as a flattened prefix: each C[k+1] is a sum of products
  // over GG/GP of groups 0..k and cin, with no group-to-group ripple
  always_comb begin
    logic v_acc;
    logic v_prod;
    w_gc    = '0;
    v_acc   = 1'b0;
    v_prod  = 1'b1;
    w_gc[0] = r_s1_cin;
    for (int unsigned k = 0; k < NG; k++) begin
      v_acc = 1'b0;
      for (int unsigned j = 0; j <= k; j++) begin
        v_prod = r_s1_gg[j];
        for (int unsigned m = j + 1; m <= k; m++) begin
          v_prod = v_prod & r_s1_gp[m];
        end
        v_acc = v_acc | v_prod;
      end
      v_prod = r_s1_cin;
      for (int unsigned m = 0; m <= k; m++) begin
        v_prod = v_prod & r_s1_gp[m];
      end
      w_gc[k+1] = v_acc | v_prod;
    end
  end

  // Bit carries inside each group from its resolved carry-in
  for (genvar k = 0; k < NG; k++) begin : g_s2_grp
    cla_group4 u_grp (
      .i_g   (r_s1_g[k*GROUP_W +: GROUP_W]),
      .i_p   (r_s1_p[k*GROUP_W +: GROUP_W]),
      .i_cin (w_gc[k]),
      .o_c   (w_c[k*GROUP_W +: GROUP_W]),
      .o_gg  (w_s2_gg[k]),
      .o_gp  (w_s2_gp[k])
    );
  end

  // Group GG/GP already arrive registered from S1; the S2 copies are not needed
  logic w_unused_s2;
  assign w_unused_s2 = ^{w_s2_gg, w_s2_gp};

  assign w_sum = r_s1_p ^ w_c;

`ifdef CLA_FLAGS_EN
  // Signed overflow: like-signed operands producing an opposite-signed sum
  assign w_ovf  = (r_s1_a_msb == r_s1_b_msb) & (w_sum[MSB] != r_s1_a_msb);
  assign w_zero = ~|w_sum;
`endif

  // Output stage: load on S1 advance, hold while stalled, empty on pop
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_out_valid <= 1'b0;
      r_sum       <= '0;
      r_cout      <= 1'b0;
`ifdef CLA_FLAGS_EN
      r_ovf       <= 1'b0;
      r_zero      <= 1'b0;
`endif
    end else if (w_s1_adv) begin
      r_out_valid <= 1'b1;
      r_sum       <= w_sum;
      r_cout      <= w_gc[NG];
`ifdef CLA_FLAGS_EN
      r_ovf       <= w_ovf;
      r_zero      <= w_zero;
`endif
    end else if (out_ready_i) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid_o = r_out_valid;
  assign sum_o       = r_sum;
  assign cout_o      = r_cout;
`ifdef CLA_FLAGS_EN
  assign ovf_o       = r_ovf;
  assign zero_o      = r_zero;
`endif

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Self-checking bench for cla_pipe_adder at WIDTH 16, 4 and 64, all three
// instances driven by the same handshake controls.
// Flags are checked when CLA_FLAGS_EN is defined.
module tb_cla_pipe_adder;

  logic clk;
  logic rst;
  logic in_valid;
  logic out_ready;
  logic cin;
  logic sub;
  logic [15:0] a16, b16;
  logic [3:0]  a4, b4;
  logic [63:0] a64, b64;

  logic        in_ready16, ov16, cout16;
  logic [15:0] sum16;
  logic        in_ready4, ov4, cout4;
  logic [3:0]  sum4;
  logic        in_ready64, ov64, cout64;
  logic [63:0] sum64;
`ifdef CLA_FLAGS_EN
  logic ovf16, zero16, ovf4, zero4, ovf64, zero64;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  cla_pipe_adder #(.WIDTH(16)) u_dut16 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready16),
    .a_i(a16), .b_i(b16), .cin_i(cin), .sub_i(sub),
    .out_valid_o(ov16), .out_ready_i(out_ready), .sum_o(sum16), .cout_o(cout16)
`ifdef CLA_FLAGS_EN
    , .ovf_o(ovf16), .zero_o(zero16)
`endif
  );

  cla_pipe_adder #(.WIDTH(4)) u_dut4 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready4),
    .a_i(a4), .b_i(b4), .cin_i(cin), .sub_i(sub),
    .out_valid_o(ov4), .out_ready_i(out_ready), .sum_o(sum4), .cout_o(cout4)
`ifdef CLA_FLAGS_EN
    , .ovf_o(ovf4), .zero_o(zero4)
`endif
  );

  cla_pipe_adder #(.WIDTH(64)) u_dut64 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready64),
    .a_i(a64), .b_i(b64), .cin_i(cin), .sub_i(sub),
    .out_valid_o(ov64), .out_ready_i(out_ready), .sum_o(sum64), .cout_o(cout64)
`ifdef CLA_FLAGS_EN
    , .ovf_o(ovf64), .zero_o(zero64)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;
  int n_pop   = 0;

  // Expected {cout, sum} per instance, in acceptance order
  logic [16:0] q16[$];
  logic [4:0]  q4[$];
  logic [64:0] q64[$];
`ifdef CLA_FLAGS_EN
  logic [1:0]  qf16[$];
  logic [1:0]  qf4[$];
  logic [1:0]  qf64[$];
`endif

  logic        hold_valid = 1'b0;
  logic [16:0] held16;
  logic        acc_last = 1'b0;
  logic        have = 1'b0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // {cout, sum} of a w-bit add/sub computed with plain integer arithmetic
  function automatic logic [65:0] ref_sum(input logic [63:0] a, input logic [63:0] b,
                                          input logic c, input logic s, input int unsigned w);
    logic [65:0] r, mask;
    mask = (66'd1 << (w + 1)) - 66'd1;
    if (s) r = {2'b0, a} + (66'd1 << w) - {2'b0, b};
    else   r = {2'b0, a} + {2'b0, b} + {65'd0, c};
    return r & mask;
  endfunction

  // {ovf, zero}: overflow when the true signed result leaves the w-bit range
  function automatic logic [1:0] ref_flags(input logic [63:0] a, input logic [63:0] b,
                                           input logic c, input logic s, input int unsigned w,
                                           input logic [65:0] rs);
    logic signed [65:0] sa, sb, r, lim;
    logic ovf, zero;
    lim = 66'sd1 <<< (w - 1);
    sa = $signed({2'b0, a});
    sb = $signed({2'b0, b});
    if (a[w-1]) sa = sa - (66'sd1 <<< w);
    if (b[w-1]) sb = sb - (66'sd1 <<< w);
    r = s ? (sa - sb) : (sa + sb + $signed({65'd0, c}));
    ovf  = (r >= lim) || (r < -lim);
    zero = ((rs & ((66'd1 << w) - 66'd1)) == 66'd0);
    return {ovf, zero};
  endfunction

  // Samples the cycle's handshake just before the rising edge
  task automatic observe();
    logic exp_rdy;
    logic [65:0] t;
    if (rst) begin
      q16.delete(); q4.delete(); q64.delete();
`ifdef CLA_FLAGS_EN
      qf16.delete(); qf4.delete(); qf64.delete();
`endif
      hold_valid = 1'b0;
      acc_last   = 1'b0;
      return;
    end
    // Two beats of storage; a full block still accepts when the output pops
    exp_rdy = (q16.size() < 2) || out_ready;
    check("in_ready16", in_ready16, exp_rdy);
    check("in_ready4",  in_ready4,  exp_rdy);
    check("in_ready64", in_ready64, exp_rdy);

    if (hold_valid) begin
      check("stall_valid", ov16, 1'b1);
      check("stall_result", {cout16, sum16}, held16);
    end
    if (ov16) begin
      if (q16.size() == 0) check("spurious16", ov16, 1'b0);
      else if (out_ready) begin
        check("res16", {cout16, sum16}, q16.pop_front());
`ifdef CLA_FLAGS_EN
        check("flags16", {ovf16, zero16}, qf16.pop_front());
`endif
        n_pop++;
      end
    end
    hold_valid = ov16 && !out_ready;
    held16     = {cout16, sum16};

    if (ov4) begin
      if (q4.size() == 0) check("spurious4", ov4, 1'b0);
      else if (out_ready) begin
        check("res4", {cout4, sum4}, q4.pop_front());
`ifdef CLA_FLAGS_EN
        check("flags4", {ovf4, zero4}, qf4.pop_front());
`endif
      end
    end
    if (ov64) begin
      if (q64.size() == 0) check("spurious64", ov64, 1'b0);
      else if (out_ready) begin
        check("res64", {cout64, sum64}, q64.pop_front());
`ifdef CLA_FLAGS_EN
        check("flags64", {ovf64, zero64}, qf64.pop_front());
`endif
      end
    end

    acc_last = in_valid && exp_rdy;
    if (acc_last) begin
      t = ref_sum({48'd0, a16}, {48'd0, b16}, cin, sub, 16);
      q16.push_back(t[16:0]);
`ifdef CLA_FLAGS_EN
      qf16.push_back(ref_flags({48'd0, a16}, {48'd0, b16}, cin, sub, 16, t));
`endif
      t = ref_sum({60'd0, a4}, {60'd0, b4}, cin, sub, 4);
      q4.push_back(t[4:0]);
`ifdef CLA_FLAGS_EN
      qf4.push_back(ref_flags({60'd0, a4}, {60'd0, b4}, cin, sub, 4, t));
`endif
      t = ref_sum(a64, b64, cin, sub, 64);
      q64.push_back(t[64:0]);
`ifdef CLA_FLAGS_EN
      qf64.push_back(ref_flags(a64, b64, cin, sub, 64, t));
`endif
    end
  endtask

  // Called at a falling edge with inputs already set; returns at the next one
  task automatic tick();
    #1;
    observe();
    @(negedge clk);
  endtask

  function automatic logic [15:0] pick16();
    case ($urandom_range(7))
      0: return 16'hFFFF;
      1: return 16'h7FFF;
      2: return 16'h8000;
      3: return 16'h0000;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic new_beat();
    a16 = pick16();
    b16 = pick16();
    a4  = 4'($urandom);
    b4  = 4'($urandom);
    a64 = {$urandom, $urandom};
    b64 = ($urandom_range(3) == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : {$urandom, $urandom};
    cin = 1'($urandom_range(1));
    sub = 1'($urandom_range(1));
  endtask

  // Single beat through an empty pipe, checking 2-cycle latency and values
  task automatic send_one(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic c, input logic s, input logic [15:0] exp_sum,
                          input logic exp_cout, input logic exp_ovf, input logic exp_zero);
    new_beat();
    a16 = a; b16 = b; cin = c; sub = s;
    in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check({tag, "_lat1"}, ov16, 1'b0);
    tick();
    check({tag, "_lat2"}, ov16, 1'b1);
    check({tag, "_sum"}, sum16, exp_sum);
    check({tag, "_cout"}, cout16, exp_cout);
`ifdef CLA_FLAGS_EN
    check({tag, "_ovf"}, ovf16, exp_ovf);
    check({tag, "_zero"}, zero16, exp_zero);
`else
    if (exp_ovf && exp_zero) a16 = 16'h0;
`endif
    tick();
  endtask

  // Offers n more beats (holding each until accepted) and drains the pipe
  task automatic run(input int n, input int rdy_pct, input int vld_pct, output int cycles);
    int sent = 0;
    cycles = 0;
    while ((sent < n || have || q16.size() > 0) && cycles < 5000) begin
      if (!have && sent < n && $urandom_range(99) < vld_pct) begin
        new_beat();
        have = 1'b1;
      end
      in_valid  = have;
      out_ready = ($urandom_range(99) < rdy_pct);
      tick();
      if (acc_last) begin
        have = 1'b0;
        sent++;
      end
      cycles++;
    end
    in_valid = 1'b0;
    check("run_bounded", {31'd0, cycles >= 5000}, 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int pops0;
    int acc;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    cin = 1'b0; sub = 1'b0;
    a16 = '0; b16 = '0; a4 = '0; b4 = '0; a64 = '0; b64 = '0;
    @(negedge clk);
    tick();
    tick();
    rst = 1'b0;
    check("rst_out_valid", ov16, 1'b0);
    check("rst_sum", sum16, 16'h0);
    check("rst_cout", cout16, 1'b0);
    check("rst_in_ready", in_ready16, 1'b1);
`ifdef CLA_FLAGS_EN
    check("rst_ovf", ovf16, 1'b0);
    check("rst_zero", zero16, 1'b0);
`endif

    // Directed corner cases
    send_one("add_wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    send_one("sub_neg",  16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
    send_one("sub_pos",  16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b0);
    send_one("add_ovf",  16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);

    // Backpressure: four cycles of offers with the consumer stalled
    out_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 4; i++) begin
      if (!have) begin
        new_beat();
        have = 1'b1;
      end
      in_valid = 1'b1;
      #1;
      if (i >= 2) check("bp_in_ready", in_ready16, 1'b0);
      tick();
      if (acc_last) begin
        acc++;
        have = 1'b0;
      end
    end
    check("bp_accepted", acc, 2);
    run(2, 100, 100, cyc);

    // Back-to-back at full rate
    pops0 = n_pop;
    run(100, 100, 100, cyc);
    check("b2b_cycles", cyc, 102);
    check("b2b_pops", n_pop - pops0, 100);

    // Random valid and random ready
    pops0 = n_pop;
    run(150, 50, 70, cyc);
    check("rand_pops", n_pop - pops0, 150);

    // Reset with two beats in flight
    out_ready = 1'b0;
    in_valid  = 1'b1;
    new_beat();
    tick();
    new_beat();
    tick();
    check("pre_rst_occ", q16.size(), 2);
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_valid16", ov16, 1'b0);
    check("mid_rst_valid4", ov4, 1'b0);
    check("mid_rst_valid64", ov64, 1'b0);
    check("mid_rst_in_ready", in_ready16, 1'b1);
    out_ready = 1'b1;
    tick();
    tick();
    send_one("post_rst", 16'h1234, 16'h0FF0, 1'b1, 1'b0, 16'h2225, 1'b0, 1'b0, 1'b0);

    run(0, 100, 0, cyc);
    check("drain16", q16.size(), 0);
    check("drain4", q4.size(), 0);
    check("drain64", q64.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
